// File: rtl/ad_ip_jesd204_tpl_dac_framer_sync.sv
// TPL DAC framer with sync arming: DMA beats are queued in a small FIFO, held
// until a sync event releases them, then masked per channel and framed onto
// JESD204 lanes. Underflows in RUN send zeros and are counted (saturating).
module ad_ip_jesd204_tpl_dac_framer_sync #(
  parameter int NUM_LANES         = 4,
  parameter int NUM_CHANNELS      = 2,
  parameter int SAMPLES_PER_FRAME = 1,
  parameter int BITS_PER_SAMPLE   = 16,
  parameter int OCTETS_PER_BEAT   = 4,
  parameter int FIFO_ADDR_WIDTH   = 3,
  localparam int W = NUM_LANES * OCTETS_PER_BEAT * 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [W-1:0]               s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [NUM_CHANNELS-1:0]    enable,
  input  logic                       sync_arm,
  input  logic                       sync_bypass,
  input  logic                       external_sync,
  output logic [W-1:0]               link_data,
  output logic                       link_valid,
  input  logic                       link_ready,
  output logic                       dunf,
  output logic [15:0]                dunf_count,
  output logic [1:0]                 state,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_level
);

  localparam int L     = NUM_LANES;
  localparam int M     = NUM_CHANNELS;
  localparam int S     = SAMPLES_PER_FRAME;
  localparam int NP    = BITS_PER_SAMPLE;
  localparam int OPB   = OCTETS_PER_BEAT;
  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int F     = (M * S * NP) / (8 * L);
  localparam int FPB   = OPB / F;
  localparam int DPW   = FPB * S;
  localparam int FB    = M * S * NP;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10
  } state_t;

  state_t          state_reg;
  logic            sync_q_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     level_reg;
  logic [W-1:0]    link_data_reg;
  logic            link_valid_reg;
  logic            dunf_reg;
  logic [15:0]     dunf_count_reg;

  logic [W-1:0]    mem [DEPTH];
  logic [W-1:0]    head;
  logic [W-1:0]    framed;

  logic            empty;
  logic            full;
  logic            in_run;
  logic            flush;
  logic            push;
  logic            pop;
  logic            underflow;
  logic            sync_edge;

  assign empty     = (level_reg == '0);
  assign full      = (level_reg == (AW+1)'(DEPTH));
  assign in_run    = (state_reg == RUN);
  assign flush     = in_run && sync_arm;
  assign s_ready   = (state_reg != IDLE) && !full;
  assign push      = s_valid && s_ready && !flush;
  assign pop       = in_run && link_ready && !empty;
  assign underflow = in_run && link_ready && empty;
  assign sync_edge = external_sync && !sync_q_reg;
  assign head      = mem[rd_ptr_reg];

  // Framing: each frame is a MSB-first bitstream of all channel samples,
  // whose octets are spread over lanes F at a time. Masked channels send 0.
  for (genvar gi = 0; gi < FPB; gi++) begin : g_frame
    logic [FB-1:0] frame_bits;
    for (genvar gj = 0; gj < M * S; gj++) begin : g_sample
      localparam int C = gj / S;
      localparam int K = gi * S + gj % S;
      assign frame_bits[FB-1-gj*NP -: NP] = enable[C] ? head[(C*DPW+K)*NP +: NP] : '0;
    end
    for (genvar gk = 0; gk < FB / 8; gk++) begin : g_octet
      assign framed[(gk/F)*8*OPB + 8*(gi*F + gk%F) +: 8] = frame_bits[FB-1-8*gk -: 8];
    end
  end

  // Sync FSM: arm from IDLE/RUN, release to RUN on sync edge or bypass.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      sync_q_reg <= 1'b0;
    end else begin
      sync_q_reg <= external_sync;
      case (state_reg)
        IDLE:    if (sync_arm) state_reg <= ARMED;
        ARMED:   if (sync_bypass || sync_edge) state_reg <= RUN;
        RUN:     if (sync_arm) state_reg <= ARMED;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // FIFO storage; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= s_data;
  end

  // FIFO pointers and level; re-arming from RUN discards everything queued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Link output register: advances only when the link consumes a beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      link_data_reg  <= '0;
      link_valid_reg <= 1'b0;
    end else begin
      link_valid_reg <= 1'b1;
      if (link_ready) link_data_reg <= pop ? framed : '0;
    end
  end

  // Underflow pulse and saturating counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dunf_reg       <= 1'b0;
      dunf_count_reg <= '0;
    end else begin
      dunf_reg <= underflow;
      if (underflow && (dunf_count_reg != 16'hFFFF)) dunf_count_reg <= dunf_count_reg + 16'd1;
    end
  end

  assign link_data  = link_data_reg;
  assign link_valid = link_valid_reg;
  assign dunf       = dunf_reg;
  assign dunf_count = dunf_count_reg;
  assign state      = state_reg;
  assign fifo_level = level_reg;

endmodule
